// File: rtl/cop0_intc.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cop0_intc : COP0 Status/Cause/EPC plus exception/interrupt redirect sequencer
// Revision  : 1.0
// ---------------------------------------------------------------------------
module cop0_intc #(
    parameter int          NUM_IRQ      = 3,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [31:0]        pc_next,
    input  logic               is_syscall,
    input  logic               is_eret,
    input  logic               is_mtc0,
    input  logic [4:0]         cop0_rd,
    input  logic [31:0]        cop0_wdata,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [31:0]        cop0_rdata,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_handler
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 ie_q, ie_d;
    logic [NUM_IRQ-1:0]   im_q, im_d;
    logic [4:0]           exc_code_q, exc_code_d;
    logic [31:0]          epc_q, epc_d;
    logic [NUM_IRQ-1:0]   pend_q, pend_d;
    logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0]   ack_sel_q, ack_sel_d;

    logic [NUM_IRQ-1:0]   w_edge;
    logic [NUM_IRQ-1:0]   w_cand;
    logic [NUM_IRQ-1:0]   w_pick;
    logic [31:0]          w_status;
    logic [31:0]          w_cause;
    logic                 unused_wdata;

    assign unused_wdata = ^cop0_wdata;

    always_comb begin
        w_edge  = irq_req & ~irq_prev_q;
        w_cand  = pend_q & im_q & {NUM_IRQ{ie_q}};
        // isolate the lowest set bit so the lowest index wins
        w_pick  = w_cand & (~w_cand + NUM_IRQ'(1));

        redirect    = (state_q == ST_ENTER) || (state_q == ST_RETURN);
        redirect_pc = (state_q == ST_ENTER)  ? HANDLER_ADDR :
                      (state_q == ST_RETURN) ? epc_q : 32'h0;
        irq_ack     = (state_q == ST_ENTER) ? ack_sel_q : '0;
        in_handler  = (state_q == ST_HANDLER);

        w_status                 = 32'h0;
        w_status[0]              = ie_q;
        w_status[8 +: NUM_IRQ]   = im_q;
        w_cause                  = 32'h0;
        w_cause[6:2]             = exc_code_q;
        w_cause[8 +: NUM_IRQ]    = pend_q;

        case (cop0_rd)
            5'd12:   cop0_rdata = w_status;
            5'd13:   cop0_rdata = w_cause;
            5'd14:   cop0_rdata = epc_q;
            default: cop0_rdata = 32'h0;
        endcase

        state_d    = state_q;
        ie_d       = ie_q;
        im_d       = im_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        ack_sel_d  = ack_sel_q;
        irq_prev_d = irq_req;
        // a new edge in the ack cycle re-arms the line
        pend_d     = (pend_q & ~irq_ack) | w_edge;

        if (instr_valid && is_mtc0) begin
            if (cop0_rd == 5'd12) begin
                ie_d = cop0_wdata[0];
                im_d = cop0_wdata[8 +: NUM_IRQ];
            end else if (cop0_rd == 5'd14) begin
                epc_d = cop0_wdata;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (instr_valid && (is_syscall || (|w_cand))) begin
                    epc_d      = pc_next;
                    ie_d       = 1'b0;
                    state_d    = ST_ENTER;
                    exc_code_d = is_syscall ? 5'd8 : 5'd0;
                    ack_sel_d  = is_syscall ? '0 : w_pick;
                end
            end
            ST_ENTER: begin
                ack_sel_d = '0;
                state_d   = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (instr_valid && is_eret) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                ie_d    = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ie_q       <= 1'b0;
            im_q       <= '0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'h0;
            pend_q     <= '0;
            irq_prev_q <= '0;
            ack_sel_q  <= '0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            im_q       <= im_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
            pend_q     <= pend_d;
            irq_prev_q <= irq_prev_d;
            ack_sel_q  <= ack_sel_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cop0_intc.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cop0_intc : scoreboard bench for cop0_intc redirects and COP0 registers
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_cop0_intc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] pc_next;
    logic        is_syscall;
    logic        is_eret;
    logic        is_mtc0;
    logic [4:0]  cop0_rd;
    logic [31:0] cop0_wdata;
    logic [2:0]  irq_req;
    logic [31:0] cop0_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  irq_ack;
    logic        in_handler;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  ack;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    cop0_intc #(.NUM_IRQ(3), .HANDLER_ADDR(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .pc_next     (pc_next),
        .is_syscall  (is_syscall),
        .is_eret     (is_eret),
        .is_mtc0     (is_mtc0),
        .cop0_rd     (cop0_rd),
        .cop0_wdata  (cop0_wdata),
        .irq_req     (irq_req),
        .cop0_rdata  (cop0_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irq_ack     (irq_ack),
        .in_handler  (in_handler)
    );

    always #5 clk = ~clk;

    // Monitor: every redirect must match the oldest expectation
    always @(negedge clk) begin
        n_checks++;
        if (redirect) begin
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_redirect: got pc=%h ack=%b, expected no redirect",
                         redirect_pc, irq_ack);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (redirect_pc !== e.pc || irq_ack !== e.ack) begin
                    n_fails++;
                    $display("FAIL redirect: got pc=%h ack=%b, expected pc=%h ack=%b",
                             redirect_pc, irq_ack, e.pc, e.ack);
                end
            end
        end else if (redirect_pc !== 32'h0 || irq_ack !== 3'b000) begin
            n_fails++;
            $display("FAIL idle_outputs: got pc=%h ack=%b, expected 0 and 000",
                     redirect_pc, irq_ack);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [4:0] idx, input logic [31:0] exp);
        cop0_rd = idx;
        #1;
        chk(name, cop0_rdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic retire(input logic [31:0] pc, input logic sys, input logic eret,
                          input logic mtc0, input logic [4:0] rd, input logic [31:0] wd);
        instr_valid = 1'b1;
        pc_next     = pc;
        is_syscall  = sys;
        is_eret     = eret;
        is_mtc0     = mtc0;
        cop0_rd     = rd;
        cop0_wdata  = wd;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        is_syscall  = 1'b0;
        is_eret     = 1'b0;
        is_mtc0     = 1'b0;
    endtask

    task automatic expect_redirect(input logic [31:0] pc, input logic [2:0] ack);
        exp_t e;
        e.pc  = pc;
        e.ack = ack;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        pc_next     = 32'h0;
        is_syscall  = 1'b0;
        is_eret     = 1'b0;
        is_mtc0     = 1'b0;
        cop0_rd     = 5'd0;
        cop0_wdata  = 32'h0;
        irq_req     = 3'b000;
        idle(2);
        rst_n = 1'b1;

        rd_chk("reset_status", 5'd12, 32'h0);
        rd_chk("reset_cause",  5'd13, 32'h0);
        rd_chk("reset_epc",    5'd14, 32'h0);
        chk("reset_in_handler", {31'h0, in_handler}, 32'h0);

        // Syscall entry and return
        expect_redirect(32'h0000_3000, 3'b000);
        retire(32'h0040_0010, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1);
        rd_chk("sys_epc",    5'd14, 32'h0040_0010);
        rd_chk("sys_cause",  5'd13, 32'h0000_0020);
        rd_chk("sys_status", 5'd12, 32'h0);
        chk("sys_in_handler", {31'h0, in_handler}, 32'h1);
        expect_redirect(32'h0040_0010, 3'b000);
        retire(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        idle(1);
        rd_chk("eret_status", 5'd12, 32'h1);

        // Masked irq then unmask
        retire(32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0101);
        irq_req = 3'b010;
        idle(1);
        rd_chk("masked_cause", 5'd13, 32'h0000_0220);
        retire(32'h0000_0080, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        retire(32'h0000_0090, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0201);
        expect_redirect(32'h0000_3000, 3'b010);
        retire(32'h0000_0100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1);
        rd_chk("irq1_cause", 5'd13, 32'h0);
        rd_chk("irq1_epc",   5'd14, 32'h0000_0100);
        expect_redirect(32'h0000_0100, 3'b000);
        retire(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        irq_req = 3'b000;
        idle(1);

        // Syscall beats simultaneous irq edges; irqs serviced lowest first
        retire(32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0701);
        irq_req = 3'b101;
        expect_redirect(32'h0000_3000, 3'b000);
        retire(32'h0000_0200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1);
        rd_chk("prio_cause", 5'd13, 32'h0000_0520);
        expect_redirect(32'h0000_0200, 3'b000);
        retire(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        idle(1);
        expect_redirect(32'h0000_3000, 3'b001);
        retire(32'h0000_0300, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1);
        rd_chk("prio_irq0_cause", 5'd13, 32'h0000_0400);
        expect_redirect(32'h0000_0300, 3'b000);
        retire(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        idle(1);
        expect_redirect(32'h0000_3000, 3'b100);
        retire(32'h0000_0400, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1);
        expect_redirect(32'h0000_0400, 3'b000);
        retire(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        irq_req = 3'b000;
        idle(1);

        // No nesting inside the handler
        expect_redirect(32'h0000_3000, 3'b000);
        retire(32'h0000_0500, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        idle(1);
        irq_req = 3'b001;
        retire(32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0701);
        retire(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        retire(32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        rd_chk("nest_cause",  5'd13, 32'h0000_0120);
        rd_chk("nest_status", 5'd12, 32'h0000_0701);
        chk("nest_in_handler", {31'h0, in_handler}, 32'h1);
        expect_redirect(32'h0000_0500, 3'b000);
        retire(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        idle(1);
        expect_redirect(32'h0000_3000, 3'b001);
        retire(32'h0000_0600, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        irq_req = 3'b000;
        idle(1);
        chk("pre_reset_in_handler", {31'h0, in_handler}, 32'h1);

        // Reset while in the handler
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rd_chk("rst_status", 5'd12, 32'h0);
        rd_chk("rst_cause",  5'd13, 32'h0);
        rd_chk("rst_epc",    5'd14, 32'h0);
        chk("rst_in_handler", {31'h0, in_handler}, 32'h0);

        // eret in RUN and mtc0 to Cause have no effect
        retire(32'h0000_0700, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        retire(32'h0, 1'b0, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF);
        idle(1);
        rd_chk("ignored_cause", 5'd13, 32'h0);
        chk("ignored_in_handler", {31'h0, in_handler}, 32'h0);

        idle(3);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
